bram_write_arbiter: RTL and testbench
=====================================

# bram_write_arbiter

Shares the PL-side write port (port B) of the 2048 x 32-bit block memory between several vector producers, e.g. NN layer outputs, that stream results for software readout. Requesters send packets of 32-bit words. Each packet is granted with round-robin priority and written word-by-word into that requester's fixed address region, starting at the region's lowest address. The block drives the BRAM port B address, data and write-enable directly; port A remains the Zynq PS read path.

## Interface
- `NREQ`, default 2: number of requesters (1..8).
- `REGION_WORDS`, default 256: words per requester region. Requester i owns addresses i*REGION_WORDS .. (i+1)*REGION_WORDS-1. Requires NREQ*REGION_WORDS <= 2048.

Ports:
- `clk` in 1: clock for the block and BRAM port B.
- `rst` in 1: reset, synchronous, active-high.
- `src_valid` in NREQ: word valid, one bit per requester.
- `src_ready` out NREQ: word accepted on valid&ready.
- `src_data` in 32*NREQ: requester i's word is in bits [32*i +: 32].
- `src_last` in NREQ: marks the final word of a packet.
- `done` out NREQ: one-cycle pulse when requester i's packet completes.
- `overflow` out NREQ: asserted together with `done` if words were dropped.
- `bram_addr` out 11: port B word address.
- `bram_din` out 32: port B write data.
- `bram_we` out 1: port B write enable.
- `busy` out 1: high while a grant is held.

## Operation
- States: IDLE, STREAM.
- **IDLE**
  - If any `src_valid` is set, pick the winner by round-robin, searching from `last_grant`+1 upward and wrapping.
  - Register the winner in `grant`, clear `idx` and the drop flag, and go to STREAM.
  - If no `src_valid` is set, stay in IDLE.
  - `src_ready` is all zero in IDLE.
- **STREAM**
  - `src_ready[grant]` = 1 combinationally; all other ready bits are 0.
  - On each accepted word where `idx` < REGION_WORDS:
    - register `bram_we`=1, `bram_addr`=grant*REGION_WORDS+idx, `bram_din`=word;
    - increment `idx`.
  - On each accepted word where `idx` == REGION_WORDS:
    - the word is consumed and dropped (`bram_we`=0);
    - the drop flag is set.
  - In any cycle with no accepted word, `bram_we`=0. Gaps in `src_valid` are legal.
  - When the accepted word has `src_last`=1:
    - pulse `done[grant]` on the next cycle, with `overflow[grant]` = drop flag;
    - set `last_grant` <= grant and return to IDLE.
- `busy` = (state == STREAM).
- Address arithmetic is 11-bit. The base is a constant per requester, and `idx` is wide enough to hold REGION_WORDS.
- Requesters that are not granted hold their data. Requests are never lost, only delayed.

## Timing
- Reset values:
  - `src_ready`, `done`, `overflow`, `busy`, `bram_we` = 0;
  - `bram_addr` = 0, `bram_din` = 0;
  - state = IDLE, `last_grant` = NREQ-1, so requester 0 has priority first.
- Arbitration takes 1 cycle: `src_valid` seen in IDLE at edge k gives `src_ready` high after edge k.
- Write latency: a word accepted at edge k is on port B after edge k and written into the BRAM at edge k+1.
- Throughput is 1 word/cycle inside a packet. There is exactly 1 IDLE cycle between packets.
- `done` is high for the single cycle after the last word's accept edge, coincident with the last `bram_we` pulse.
- A single-word packet (valid+last on the first ready cycle) is written and completed normally.
- A reset mid-packet:
  - drops the grant immediately; no `done` is issued;
  - words already written stay in memory;
  - the next arbitration starts from requester 0.
- A `src_valid` change on a non-granted requester has no effect until the next IDLE.

## Structure
- Shared package `bram_pkg`:
  - constants DATA_W=32, BRAM_ADDR_W=11, BRAM_DEPTH=2048;
  - state encoding (IDLE, STREAM).
- Sub-module `rr_arbiter`, parameter N:
  - inputs: request vector, `last_grant`;
  - outputs: one-hot grant plus index;
  - purely combinational.
- The top level holds the FSM, `idx` counter, drop flag and port B registers.

## Test plan
- **Single requester:** NREQ=2, REGION_WORDS=256. Requester 0 sends 4 words 0x11..0x44 with last on 0x44 -> writes to addresses 0..3 on 4 consecutive cycles; `done[0]` pulses once; `overflow[0]`=0.
- **Contention:** both requesters valid in the same cycle after reset.
  - Requester 0 is served first; its 3 words go to addr 0..2.
  - One IDLE cycle follows.
  - Requester 1's 3 words go to addr 256..258, and `src_ready[1]` is 0 throughout packet 0.
- **Fairness:** both requesters continuously valid with 2-word packets -> grants alternate 0,1,0,1 over 4 packets.
- **Overflow:** REGION_WORDS=4, requester 1 sends 6 words ->
  - addr 4..7 are written;
  - the last 2 words are accepted with `bram_we`=0;
  - `done[1]` and `overflow[1]` pulse together.
- **Valid gaps:** requester 0 drops valid every other cycle for a 3-word packet -> `bram_we` is 0 in the gap cycles and addresses stay contiguous 0..2.
- **Reset mid-packet:** assert `rst` after 2 of 5 words ->
  - no `done`; all outputs return to reset values the next cycle;
  - a new packet from requester 1 is granted afterward, since requester 0 is idle.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared constants, state encoding and helpers for the BRAM port-B write arbiter.
package bram_pkg;

    localparam int DATA_W      = 32;
    localparam int BRAM_ADDR_W = 11;
    localparam int BRAM_DEPTH  = 2048;

    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_STREAM = 1'b1;

    typedef logic [DATA_W-1:0]      word_t;
    typedef logic [BRAM_ADDR_W-1:0] bram_addr_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_grant+1, wrapping at N-1.
module rr_arbiter
    import bram_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = grant_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [N-1:0]  grant_onehot,
    output logic [GW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [GW-1:0] cand;
    logic          found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = last_grant;
        for (int off = 0; off < N; off++) begin
            cand = (cand == GW'(N - 1)) ? '0 : cand + GW'(1);
            if (!found && req[cand]) begin
                found              = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
            end
        end
        grant_valid = found;
    end

endmodule

// File: rtl/bram_write_arbiter.sv
// Round-robin packet arbiter that streams requester words into fixed BRAM port-B regions.
module bram_write_arbiter
    import bram_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int REGION_WORDS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        src_valid,
    output logic [NREQ-1:0]        src_ready,
    input  logic [DATA_W*NREQ-1:0] src_data,
    input  logic [NREQ-1:0]        src_last,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        overflow,
    output logic [BRAM_ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0]      bram_din,
    output logic                   bram_we,
    output logic                   busy
);

    localparam int GW = grant_width(NREQ);
    localparam int IW = $clog2(REGION_WORDS + 1);

    word_t      src_word    [NREQ];
    bram_addr_t region_base [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign src_word[gi]    = src_data[DATA_W*gi +: DATA_W];
            assign region_base[gi] = BRAM_ADDR_W'(gi * REGION_WORDS);
        end
    endgenerate

    logic [0:0]       state_reg,      state_next;
    logic [GW-1:0]    grant_reg,      grant_next;
    logic [NREQ-1:0]  grant_oh_reg,   grant_oh_next;
    logic [GW-1:0]    last_grant_reg, last_grant_next;
    logic [IW-1:0]    idx_reg,        idx_next;
    logic             drop_reg,       drop_next;
    logic             bram_we_reg,    bram_we_next;
    bram_addr_t       bram_addr_reg,  bram_addr_next;
    word_t            bram_din_reg,   bram_din_next;
    logic [NREQ-1:0]  done_reg,       done_next;
    logic [NREQ-1:0]  overflow_reg,   overflow_next;

    logic [NREQ-1:0]  arb_onehot;
    logic [GW-1:0]    arb_idx;
    logic             arb_valid;
    logic             accept;
    logic             room;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req          (src_valid),
        .last_grant   (last_grant_reg),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .grant_valid  (arb_valid)
    );

    assign busy      = (state_reg == STATE_STREAM);
    assign src_ready = busy ? grant_oh_reg : '0;
    assign accept    = busy && src_valid[grant_reg];
    assign room      = (idx_reg < IW'(REGION_WORDS));

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        grant_oh_next   = grant_oh_reg;
        last_grant_next = last_grant_reg;
        idx_next        = idx_reg;
        drop_next       = drop_reg;
        bram_we_next    = 1'b0;
        bram_addr_next  = bram_addr_reg;
        bram_din_next   = bram_din_reg;
        done_next       = '0;
        overflow_next   = '0;

        case (state_reg)
            STATE_IDLE: begin
                if (arb_valid) begin
                    grant_next    = arb_idx;
                    grant_oh_next = arb_onehot;
                    idx_next      = '0;
                    drop_next     = 1'b0;
                    state_next    = STATE_STREAM;
                end
            end
            STATE_STREAM: begin
                if (accept) begin
                    if (room) begin
                        bram_we_next   = 1'b1;
                        bram_addr_next = region_base[grant_reg] + BRAM_ADDR_W'(idx_reg);
                        bram_din_next  = src_word[grant_reg];
                        idx_next       = idx_reg + IW'(1);
                    end else begin
                        drop_next = 1'b1;
                    end
                    // A dropped final word must still be reported as overflow.
                    if (src_last[grant_reg]) begin
                        done_next       = grant_oh_reg;
                        overflow_next   = (drop_reg || !room) ? grant_oh_reg : '0;
                        last_grant_next = grant_reg;
                        state_next      = STATE_IDLE;
                    end
                end
            end
            default: state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= STATE_IDLE;
            grant_reg      <= '0;
            grant_oh_reg   <= '0;
            last_grant_reg <= GW'(NREQ - 1);
            idx_reg        <= '0;
            drop_reg       <= 1'b0;
            bram_we_reg    <= 1'b0;
            bram_addr_reg  <= '0;
            bram_din_reg   <= '0;
            done_reg       <= '0;
            overflow_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            grant_oh_reg   <= grant_oh_next;
            last_grant_reg <= last_grant_next;
            idx_reg        <= idx_next;
            drop_reg       <= drop_next;
            bram_we_reg    <= bram_we_next;
            bram_addr_reg  <= bram_addr_next;
            bram_din_reg   <= bram_din_next;
            done_reg       <= done_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign bram_we   = bram_we_reg;
    assign bram_addr = bram_addr_reg;
    assign bram_din  = bram_din_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Scoreboard bench: two arbiter instances (256-word and 4-word regions) with directed packets.
module tb_bram_write_arbiter;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [1:0] done;
        logic [1:0] ovf;
        logic       we;
    } done_t;

    logic        clk;
    logic        rst;
    logic        mon_en;
    int          checks;
    int          failures;

    logic [1:0]  valid_a, ready_a, last_a, done_a, ovf_a;
    logic [31:0] dw_a [2];
    logic [63:0] data_a;
    logic [10:0] addr_a;
    logic [31:0] din_a;
    logic        we_a, busy_a;

    logic [1:0]  valid_b, ready_b, last_b, done_b, ovf_b;
    logic [31:0] dw_b [2];
    logic [63:0] data_b;
    logic [10:0] addr_b;
    logic [31:0] din_b;
    logic        we_b, busy_b;

    wr_t   exp_wr_a   [$];
    wr_t   exp_wr_b   [$];
    done_t exp_done_a [$];
    done_t exp_done_b [$];

    assign data_a = {dw_a[1], dw_a[0]};
    assign data_b = {dw_b[1], dw_b[0]};

    bram_write_arbiter #(.NREQ(2), .REGION_WORDS(256)) dut_a (
        .clk(clk), .rst(rst),
        .src_valid(valid_a), .src_ready(ready_a), .src_data(data_a), .src_last(last_a),
        .done(done_a), .overflow(ovf_a),
        .bram_addr(addr_a), .bram_din(din_a), .bram_we(we_a), .busy(busy_a)
    );

    bram_write_arbiter #(.NREQ(2), .REGION_WORDS(4)) dut_b (
        .clk(clk), .rst(rst),
        .src_valid(valid_b), .src_ready(ready_b), .src_data(data_b), .src_last(last_b),
        .done(done_b), .overflow(ovf_b),
        .bram_addr(addr_b), .bram_din(din_b), .bram_we(we_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_wr(input int d, input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = 11'(addr);
        e.data = data;
        if (d == 0) exp_wr_a.push_back(e);
        else        exp_wr_b.push_back(e);
    endfunction

    function automatic void push_done(input int d, input logic [1:0] dn, input logic [1:0] ov,
                                      input logic we);
        done_t e;
        e.done = dn;
        e.ovf  = ov;
        e.we   = we;
        if (d == 0) exp_done_a.push_back(e);
        else        exp_done_b.push_back(e);
    endfunction

    function automatic bit pop_wr(input int d, output wr_t e);
        e = '0;
        if (d == 0) begin
            if (exp_wr_a.size() == 0) return 1'b0;
            e = exp_wr_a.pop_front();
        end else begin
            if (exp_wr_b.size() == 0) return 1'b0;
            e = exp_wr_b.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic bit pop_done(input int d, output done_t e);
        e = '0;
        if (d == 0) begin
            if (exp_done_a.size() == 0) return 1'b0;
            e = exp_done_a.pop_front();
        end else begin
            if (exp_done_b.size() == 0) return 1'b0;
            e = exp_done_b.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic mon_port(input int d, input logic we, input logic [10:0] addr,
                            input logic [31:0] din, input logic [1:0] dn, input logic [1:0] ov,
                            input logic [1:0] rdy, input logic bsy);
        wr_t   ew;
        done_t ed;
        checks++;
        if (!$onehot0(rdy) || (!bsy && rdy != 2'b00) || (bsy && rdy == 2'b00)) begin
            failures++;
            $display("FAIL ready_dut%0d: got ready=%b busy=%b expected one-hot while busy, zero while idle",
                     d, rdy, bsy);
        end
        if (we) begin
            $display("dut%0d write addr=%0d data=%h", d, addr, din);
            if (!pop_wr(d, ew)) begin
                chk($sformatf("unexpected_write_dut%0d", d), {21'd0, addr, din}, 64'd0);
            end else begin
                chk($sformatf("write_dut%0d", d), {21'd0, addr, din}, {21'd0, ew.addr, ew.data});
            end
        end
        if (dn != 2'b00 || ov != 2'b00) begin
            $display("dut%0d done=%b overflow=%b we=%b", d, dn, ov, we);
            if (!pop_done(d, ed)) begin
                chk($sformatf("unexpected_done_dut%0d", d), {59'd0, dn, ov, we}, 64'd0);
            end else begin
                chk($sformatf("done_dut%0d", d), {59'd0, dn, ov, we}, {59'd0, ed.done, ed.ovf, ed.we});
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_port(0, we_a, addr_a, din_a, done_a, ovf_a, ready_a, busy_a);
            mon_port(1, we_b, addr_b, din_b, done_b, ovf_b, ready_b, busy_b);
        end
    end

    task automatic set_in(input int d, input int r, input logic v, input logic [31:0] w,
                          input logic l);
        if (d == 0) begin
            valid_a[r[0]] = v;
            dw_a[r[0]]    = w;
            last_a[r[0]]  = l;
        end else begin
            valid_b[r[0]] = v;
            dw_b[r[0]]    = w;
            last_b[r[0]]  = l;
        end
    endtask

    function automatic logic get_ready(input int d, input int r);
        return (d == 0) ? ready_a[r[0]] : ready_b[r[0]];
    endfunction

    // Streams n words first, first+step, ...; optional one-cycle valid gap after each word;
    // stop_after>0 abandons the packet after that many accepted words.
    task automatic drive(input int d, input int r, input int n, input logic [31:0] first,
                         input logic [31:0] step, input bit gaps, input int stop_after);
        int waited;
        for (int k = 0; k < n; k++) begin
            if (stop_after > 0 && k == stop_after) break;
            set_in(d, r, 1'b1, first + 32'(k) * step, (k == n - 1));
            waited = 0;
            while (1) begin
                @(negedge clk);
                if (get_ready(d, r)) break;
                waited++;
                if (waited > 50) begin
                    checks++;
                    failures++;
                    $display("FAIL ready_timeout dut%0d req%0d: got no ready after %0d cycles, expected grant",
                             d, r, waited);
                    set_in(d, r, 1'b0, 32'd0, 1'b0);
                    return;
                end
            end
            @(posedge clk);
            #1;
            if (gaps && k < n - 1) begin
                set_in(d, r, 1'b0, 32'd0, 1'b0);
                @(posedge clk);
                #1;
            end
        end
        set_in(d, r, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},    {62'd0, ready_a}, 64'd0);
        chk({tag, "_done"},     {62'd0, done_a},  64'd0);
        chk({tag, "_overflow"}, {62'd0, ovf_a},   64'd0);
        chk({tag, "_busy"},     {63'd0, busy_a},  64'd0);
        chk({tag, "_we"},       {63'd0, we_a},    64'd0);
        chk({tag, "_addr"},     {53'd0, addr_a},  64'd0);
        chk({tag, "_din"},      {32'd0, din_a},   64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        valid_a  = '0;
        last_a   = '0;
        valid_b  = '0;
        last_b   = '0;
        dw_a[0] = '0; dw_a[1] = '0; dw_b[0] = '0; dw_b[1] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        mon_en = 1'b1;
        idle_cycles(1);

        // Single requester: 0x11..0x44 to addresses 0..3
        for (int k = 0; k < 4; k++) push_wr(0, k, 32'h11 * (k + 1));
        push_done(0, 2'b01, 2'b00, 1'b1);
        drive(0, 0, 4, 32'h11, 32'h11, 1'b0, 0);
        idle_cycles(3);

        // Contention right after reset: requester 0 first, then requester 1 at 256..258
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) push_wr(0, k, 32'hA0 + k);
        push_done(0, 2'b01, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) push_wr(0, 256 + k, 32'hB0 + k);
        push_done(0, 2'b10, 2'b00, 1'b1);
        fork
            drive(0, 0, 3, 32'hA0, 32'd1, 1'b0, 0);
            drive(0, 1, 3, 32'hB0, 32'd1, 1'b0, 0);
        join
        idle_cycles(3);

        // Fairness: continuous 2-word packets alternate 0,1,0,1
        push_wr(0, 0, 32'hC0);   push_wr(0, 1, 32'hC1);   push_done(0, 2'b01, 2'b00, 1'b1);
        push_wr(0, 256, 32'hD0); push_wr(0, 257, 32'hD1); push_done(0, 2'b10, 2'b00, 1'b1);
        push_wr(0, 0, 32'hC2);   push_wr(0, 1, 32'hC3);   push_done(0, 2'b01, 2'b00, 1'b1);
        push_wr(0, 256, 32'hD2); push_wr(0, 257, 32'hD3); push_done(0, 2'b10, 2'b00, 1'b1);
        fork
            begin
                drive(0, 0, 2, 32'hC0, 32'd1, 1'b0, 0);
                drive(0, 0, 2, 32'hC2, 32'd1, 1'b0, 0);
            end
            begin
                drive(0, 1, 2, 32'hD0, 32'd1, 1'b0, 0);
                drive(0, 1, 2, 32'hD2, 32'd1, 1'b0, 0);
            end
        join
        idle_cycles(3);

        // Overflow on the 4-word-region instance: 6 words, last 2 dropped
        for (int k = 0; k < 4; k++) push_wr(1, 4 + k, 32'hE0 + k);
        push_done(1, 2'b10, 2'b10, 1'b0);
        drive(1, 1, 6, 32'hE0, 32'd1, 1'b0, 0);
        idle_cycles(3);

        // Valid gaps: addresses stay contiguous, no writes in gap cycles
        for (int k = 0; k < 3; k++) push_wr(0, k, 32'h5A00 + k);
        push_done(0, 2'b01, 2'b00, 1'b1);
        drive(0, 0, 3, 32'h5A00, 32'd1, 1'b1, 0);
        idle_cycles(3);

        // Reset after 2 of 5 words: no done, outputs clear, requester 1 granted afterwards
        push_wr(0, 0, 32'hF0);
        push_wr(0, 1, 32'hF1);
        drive(0, 0, 5, 32'hF0, 32'd1, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        push_wr(0, 256, 32'h77);
        push_wr(0, 257, 32'h78);
        push_done(0, 2'b10, 2'b00, 1'b1);
        drive(0, 1, 2, 32'h77, 32'd1, 1'b0, 0);
        idle_cycles(5);

        chk("pending_writes_a", 64'(exp_wr_a.size()),   64'd0);
        chk("pending_writes_b", 64'(exp_wr_b.size()),   64'd0);
        chk("pending_done_a",   64'(exp_done_a.size()), 64'd0);
        chk("pending_done_b",   64'(exp_done_b.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
